// File: rtl/q_fixed_pkg.sv
// Shared Q-format constants and FSM encoding for the sequential multiplier/divider pair.
// Defaults: Q=15 fractional bits in an N=32 sign-magnitude word.
package q_fixed_pkg;

    localparam int Q_DEF = 15;
    localparam int N_DEF = 32;

    localparam logic S_IDLE = 1'b0;
    localparam logic S_RUN  = 1'b1;

    typedef enum logic {
        IDLE = S_IDLE,
        RUN  = S_RUN
    } state_t;

    localparam logic [N_DEF-1:0] ONE     = N_DEF'(1) << Q_DEF;
    localparam logic [N_DEF-2:0] MAG_MAX = '1;

endpackage

// File: rtl/qdivs_step.sv
// One restoring-division stage: shift in a numerator bit, trial-subtract |divisor|.
// Purely combinational; the caller registers the remainder.
module qdivs_step
    import q_fixed_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0] rem,
    input  logic         num_bit,
    input  logic [N-2:0] div_mag,
    output logic [N-1:0] rem_next,
    output logic         q_bit
);

    logic [N:0] trial;
    logic [N:0] dvs;

    always_comb begin
        trial    = {rem, num_bit};
        dvs      = {2'b00, div_mag};
        q_bit    = (trial >= dvs);
        rem_next = q_bit ? N'(trial - dvs) : N'(trial);
    end

endmodule

// File: rtl/qdivs.sv
// Sequential sign-magnitude Q-format divider, one quotient bit per clock (restoring).
// Latency N+Q-1 edges from accept to o_complete; define QDIVS_ROUND_EN for round-half-up (+1 edge).
module qdivs
    import q_fixed_pkg::*;
#(
    parameter int Q = Q_DEF,
    parameter int N = N_DEF
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    input  logic         i_start,
    output logic [N-1:0] o_quotient_out,
    output logic         o_complete,
    output logic         o_overflow
);

    localparam int NUM_W = N - 1 + Q;
`ifdef QDIVS_ROUND_EN
    localparam int ITERS = NUM_W + 1;
`else
    localparam int ITERS = NUM_W;
`endif
    localparam int CW = $clog2(N + Q + 1);
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    state_t           state;
    logic [ITERS-1:0] num_sr;
    logic [ITERS-2:0] quo;
    logic [N-1:0]     rem;
    logic [N-2:0]     div_mag;
    logic             sign;
    logic             div0;
    logic [CW-1:0]    cnt;

    logic [N-1:0]     rem_next;
    logic             q_bit;
    logic [ITERS-1:0] q_full;
    logic [N-2:0]     mag;
    logic             ovf_n;
`ifdef QDIVS_ROUND_EN
    logic [N-1:0]     rnd_sum;
`endif

    qdivs_step #(.N(N)) u_step (
        .rem      (rem),
        .num_bit  (num_sr[ITERS-1]),
        .div_mag  (div_mag),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    assign q_full = {quo, q_bit};

    // Final magnitude/overflow, only consumed on the last iteration.
    always_comb begin
        mag   = '0;
        ovf_n = 1'b0;
`ifdef QDIVS_ROUND_EN
        rnd_sum = {1'b0, q_full[N-1:1]} + {{(N-1){1'b0}}, q_full[0]};
        mag     = rnd_sum[N-2:0];
        ovf_n   = (|q_full[ITERS-1:N]) | rnd_sum[N-1];
`else
        mag   = q_full[N-2:0];
        ovf_n = |q_full[ITERS-1:N-1];
`endif
        if (div0) begin
            mag   = '1;
            ovf_n = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= IDLE;
            o_complete     <= 1'b1;
            o_overflow     <= 1'b0;
            o_quotient_out <= '0;
            num_sr         <= '0;
            quo            <= '0;
            rem            <= '0;
            div_mag        <= '0;
            sign           <= 1'b0;
            div0           <= 1'b0;
            cnt            <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        sign       <= i_dividend[N-1] ^ i_divisor[N-1];
                        div_mag    <= i_divisor[N-2:0];
                        div0       <= (i_divisor[N-2:0] == '0);
                        // Magnitude scaled by 2^Q (plus a guard slot when rounding), MSB-aligned.
                        num_sr     <= {{(ITERS-N+1){1'b0}}, i_dividend[N-2:0]} << (ITERS - N + 1);
                        quo        <= '0;
                        rem        <= '0;
                        cnt        <= '0;
                        o_complete <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    rem    <= rem_next;
                    quo    <= q_full[ITERS-2:0];
                    num_sr <= num_sr << 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        o_quotient_out <= {sign, mag};
                        o_overflow     <= ovf_n;
                        o_complete     <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qdivs.sv
// Directed bench for qdivs: vector table plus abort, ignored-start and back-to-back sequences.
module tb_qdivs;
    import q_fixed_pkg::*;

`ifdef QDIVS_ROUND_EN
    localparam int LAT = 47;
`else
    localparam int LAT = 46;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        start;
    logic [31:0] quotient_out;
    logic        complete;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    logic        unstable = 1'b0;
    logic [31:0] q0;

    qdivs dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_dividend     (dividend),
        .i_divisor      (divisor),
        .i_start        (start),
        .o_quotient_out (quotient_out),
        .o_complete     (complete),
        .o_overflow     (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic        ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    // Called just after an accepting edge; counts edges until o_complete is seen high.
    task automatic wait_done(input int pulse_at, output int lat);
        logic done;
        lat  = 0;
        done = 1'b0;
        while (!done && lat < 200) begin
            @(posedge clk);
            lat++;
            #1;
            if (pulse_at > 0) begin
                start    = (lat == pulse_at);
                dividend = 32'h00010000;
                divisor  = 32'h00008000;
            end
            done = complete;
            if (!done && quotient_out !== q0) unstable = 1'b1;
        end
    endtask

    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input int pulse_at,
                          output logic [31:0] q, output logic ovf, output int lat);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 32'hDEADBEEF;
        divisor  = 32'h12345678;
        chk("complete_fall", {63'd0, complete}, 64'd0);
        q0 = quotient_out;
        wait_done(pulse_at, lat);
        q   = quotient_out;
        ovf = overflow;
    endtask

    initial begin
        logic [31:0] q;
        logic        ovf;
        int          lat;
        logic        bad;

        vecs[0]  = '{32'h00018000, 32'h00010000, 32'h0000C000, 1'b0};
        vecs[1]  = '{32'h80030000, 32'h00010000, 32'h80018000, 1'b0};
        vecs[2]  = '{32'h80030000, 32'h80010000, 32'h00018000, 1'b0};
        vecs[3]  = '{32'h00008000, 32'h00000000, {1'b0, MAG_MAX}, 1'b1};
        vecs[4]  = '{32'h40000000, 32'h00004000, 32'h00000000, 1'b1};
`ifdef QDIVS_ROUND_EN
        vecs[5]  = '{32'h00008000, 32'h00018000, 32'h00002AAB, 1'b0};
`else
        vecs[5]  = '{32'h00008000, 32'h00018000, 32'h00002AAA, 1'b0};
`endif
        vecs[6]  = '{32'h00010000, 32'h00018000, 32'h00005555, 1'b0};
        vecs[7]  = '{32'h00008000, 32'h00000001, 32'h40000000, 1'b0};
        vecs[8]  = '{32'h00010000, 32'h00000001, 32'h00000000, 1'b1};
        vecs[9]  = '{32'h00000000, 32'h80008000, 32'h80000000, 1'b0};
        vecs[10] = '{32'h00028000, 32'h00002000, 32'h000A0000, 1'b0};
        vecs[11] = '{32'h7FFFFFFF, 32'h7FFFFFFF, ONE, 1'b0};

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_complete", {63'd0, complete}, 64'd1);
        chk("reset_ovf", {63'd0, overflow}, 64'd0);
        chk("reset_q", {32'd0, quotient_out}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            do_div(vecs[i].a, vecs[i].b, 0, q, ovf, lat);
            chk($sformatf("v%0d_q", i), {32'd0, q}, {32'd0, vecs[i].q});
            chk($sformatf("v%0d_ovf", i), {63'd0, ovf}, {63'd0, vecs[i].ovf});
            chk($sformatf("v%0d_lat", i), 64'(lat), 64'(LAT));
        end
        chk("stable_during_run", {63'd0, unstable}, 64'd0);

        // A start pulse mid-run must not disturb the division in flight.
        do_div(32'h00018000, 32'h00010000, 10, q, ovf, lat);
        chk("ignore_start_q", {32'd0, q}, 64'h0000C000);
        chk("ignore_start_lat", 64'(lat), 64'(LAT));
        repeat (3) @(posedge clk);
        #1;
        chk("ignore_start_idle", {63'd0, complete}, 64'd1);

        // Reset at edge 20 aborts the run with no result.
        @(negedge clk);
        dividend = 32'h00008000;
        divisor  = 32'h00018000;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_complete", {63'd0, complete}, 64'd1);
        chk("abort_ovf", {63'd0, overflow}, 64'd0);
        chk("abort_q", {32'd0, quotient_out}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bad = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (!complete || quotient_out !== 32'd0) bad = 1'b1;
        end
        chk("abort_no_result", {63'd0, bad}, 64'd0);
        do_div(32'h00018000, 32'h00010000, 0, q, ovf, lat);
        chk("post_abort_q", {32'd0, q}, 64'h0000C000);
        chk("post_abort_lat", 64'(lat), 64'(LAT));

        // Start held high: back-to-back runs, one idle cycle between them.
        @(negedge clk);
        dividend = 32'h00008000;
        divisor  = 32'h00008000;
        start    = 1'b1;
        @(posedge clk);
        #1;
        dividend = 32'h00018000;
        divisor  = 32'h00010000;
        q0 = quotient_out;
        wait_done(0, lat);
        chk("b2b_first_q", {32'd0, quotient_out}, {32'd0, ONE});
        chk("b2b_first_lat", 64'(lat), 64'(LAT));
        @(posedge clk);
        #1;
        chk("b2b_high_one_cycle", {63'd0, complete}, 64'd0);
        q0 = quotient_out;
        wait_done(0, lat);
        start = 1'b0;
        chk("b2b_second_q", {32'd0, quotient_out}, 64'h0000C000);
        chk("b2b_second_lat", 64'(lat), 64'(LAT));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
